dac_write_scheduler: RTL and testbench

- Upstream feeder for the DAC output router.
- Accepts matrix/vector element writes (address + DAC code) from the I2C register front end and queues them in a small FIFO.
- For each entry: loads the code into the DAC, waits for settling, then presents the address to the router with `o_addr_ready`/`o_dac_data_valid`.
- Generates the DAC hold-done acknowledge and completes the router's ack / clear handshake before issuing the next entry.

---
 rtl/dac_write_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_dac_write_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_write_scheduler.sv
// Queues DAC element writes and feeds them one at a time through load, settle, hold and router ack.
// Optional watchdog on the hold/ack phase is enabled by defining ACK_TIMEOUT_EN.
module dac_write_scheduler #(
    parameter int VECTOR_SIZE   = 4,
    parameter int TOTAL_OPTIONS = (VECTOR_SIZE*2)+(VECTOR_SIZE*VECTOR_SIZE),
    parameter int ADDR_WIDTH    = $clog2(TOTAL_OPTIONS),
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_wr_valid,
    input  logic [ADDR_WIDTH-1:0]              i_wr_addr,
    input  logic [DATA_WIDTH-1:0]              i_wr_data,
    output logic                               o_wr_ready,
    output logic                               o_addr_err,
    output logic [DATA_WIDTH-1:0]              o_dac_code,
    output logic                               o_dac_load,
    output logic                               o_dac_data_valid,
    output logic                               o_dac_ack,
    input  logic                               i_dac_enable,
    output logic [ADDR_WIDTH-1:0]              o_addr_out,
    output logic                               o_addr_ready,
    input  logic                               i_ack_in,
    output logic                               o_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count,
    output logic                               o_timeout_err,
    output logic [2:0]                         o_dbg_state
);

    localparam int COUNT_W = $clog2(FIFO_DEPTH+1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_MAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX+1);

    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT  = (ADDR_WIDTH+1)'(TOTAL_OPTIONS);
    localparam logic [COUNT_W-1:0]  DEPTH_L     = COUNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]    SETTLE_INIT = CNT_W'(SETTLE_CYCLES-1);
    localparam logic [CNT_W-1:0]    HOLD_INIT   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_HOLD, S_WAIT_ACK, S_RELEASE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0]   head;
    logic                 addr_ok, push, pop, timeout_hit;

    // Write side is valid/ready: a word transfers on a clock edge where i_wr_valid
    // and o_wr_ready are both high; o_wr_ready reflects the occupancy before that edge.
    assign addr_ok = ({1'b0, i_wr_addr} < ADDR_LIMIT);
    assign push    = i_wr_valid && o_wr_ready && addr_ok;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= {i_wr_addr, i_wr_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            o_wr_ready <= 1'b1;
            o_addr_err <= 1'b0;
            o_addr_out <= '0;
            o_dac_code <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                o_addr_out <= head[ENTRY_W-1:DATA_WIDTH];
                o_dac_code <= head[DATA_WIDTH-1:0];
            end
            count_q    <= count_d;
            o_wr_ready <= (count_d < DEPTH_L);
            o_addr_err <= i_wr_valid && !addr_ok;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // SETTLE runs SETTLE_CYCLES-1 cycles so data_valid rises SETTLE_CYCLES after LOAD.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        pop              = 1'b0;
        o_dac_load       = 1'b0;
        o_addr_ready     = 1'b0;
        o_dac_data_valid = 1'b0;
        o_dac_ack        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                o_dac_load   = 1'b1;
                o_addr_ready = 1'b1;
                if (SETTLE_CYCLES > 1) begin
                    cnt_d   = SETTLE_INIT;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d   = HOLD_INIT;
                    state_d = S_HOLD;
                end
            end
            S_SETTLE: begin
                o_addr_ready = 1'b1;
                cnt_d        = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    cnt_d   = HOLD_INIT;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                o_addr_ready     = 1'b1;
                o_dac_data_valid = 1'b1;
                if (i_dac_enable) begin
                    if (cnt_q <= CNT_ONE) state_d = S_WAIT_ACK;
                    else                  cnt_d   = cnt_q - CNT_ONE;
                end
            end
            S_WAIT_ACK: begin
                o_addr_ready     = 1'b1;
                o_dac_data_valid = 1'b1;
                o_dac_ack        = 1'b1;
                if (i_ack_in) state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (timeout_hit) state_d = S_RELEASE;
    end

`ifdef ACK_TIMEOUT_EN
    localparam int WD_W = $clog2(ACK_TIMEOUT+1);
    logic [WD_W-1:0] wd_q;
    logic            in_watch;
    logic            timeout_q;

    assign in_watch    = (state_q == S_HOLD) || (state_q == S_WAIT_ACK);
    assign timeout_hit = in_watch && (wd_q == WD_W'(ACK_TIMEOUT-1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= in_watch ? (wd_q + WD_W'(1)) : '0;
            if (timeout_hit) timeout_q <= 1'b1;
        end
    end

    assign o_timeout_err = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    assign o_busy       = (state_q != S_IDLE) || (count_q != '0);
    assign o_fifo_count = count_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Bench for dac_write_scheduler: write driver, router model, and a scoreboard
// of issued (address, code) pairs in write order.
module tb_dac_write_scheduler;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;
    localparam int COUNT_W   = 3;
    localparam int TOTAL     = 24;
    localparam int ACK_DELAY = 2;

    logic              i_clk, i_rst_n;
    logic              i_wr_valid;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ready, o_addr_err;
    logic [DATA_W-1:0] o_dac_code;
    logic              o_dac_load, o_dac_data_valid, o_dac_ack;
    logic              i_dac_enable;
    logic [ADDR_W-1:0] o_addr_out;
    logic              o_addr_ready, i_ack_in, o_busy;
    logic [COUNT_W-1:0] o_fifo_count;
    logic              o_timeout_err;
    logic [2:0]        o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] mon_exp, held;
    int cyc = 0, loads = 0, load_cyc = 0, dv_cyc = 0, ack_cyc = 0, last_wr_cyc = 0;
    logic prev_ready = 1'b0, prev_dv = 1'b0, prev_ack = 1'b0;
    bit router_stall = 1'b0;

    dac_write_scheduler dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_wr_valid       (i_wr_valid),
        .i_wr_addr        (i_wr_addr),
        .i_wr_data        (i_wr_data),
        .o_wr_ready       (o_wr_ready),
        .o_addr_err       (o_addr_err),
        .o_dac_code       (o_dac_code),
        .o_dac_load       (o_dac_load),
        .o_dac_data_valid (o_dac_data_valid),
        .o_dac_ack        (o_dac_ack),
        .i_dac_enable     (i_dac_enable),
        .o_addr_out       (o_addr_out),
        .o_addr_ready     (o_addr_ready),
        .i_ack_in         (i_ack_in),
        .o_busy           (o_busy),
        .o_fifo_count     (o_fifo_count),
        .o_timeout_err    (o_timeout_err),
        .o_dbg_state      (o_dbg_state)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // driver: one write attempt, one cycle of valid
    task automatic write_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output bit acc);
        @(negedge i_clk); #1;
        last_wr_cyc = cyc;
        i_wr_valid  = 1'b1;
        i_wr_addr   = a;
        i_wr_data   = d;
        acc = o_wr_ready && (int'(a) < TOTAL);
        if (acc) exp_q.push_back({a, d});
        @(posedge i_clk); #1;
        i_wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge i_clk);
            if (!o_busy && exp_q.size() == 0) break;
        end
        check(tag, (i < bound), 1);
    endtask

    // router model: acks ACK_DELAY cycles after o_dac_ack unless stalled
    initial begin
        int cnt;
        cnt = 0;
        i_ack_in = 1'b0;
        forever begin
            @(negedge i_clk); #1;
            if (!o_dac_ack) begin
                i_ack_in = 1'b0;
                cnt = 0;
            end else if (!router_stall) begin
                cnt++;
                if (cnt >= ACK_DELAY) i_ack_in = 1'b1;
            end
        end
    end

    // scoreboard / monitor
    always @(negedge i_clk) begin
        cyc++;
        if (!i_rst_n) begin
            prev_ready = 1'b0;
            prev_dv    = 1'b0;
            prev_ack   = 1'b0;
        end else begin
            if (o_dac_load) begin
                loads++;
                load_cyc = cyc;
                check("gap_before_load", prev_ready, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_load", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("issue_entry", {o_addr_out, o_dac_code}, mon_exp);
                end
                held = {o_addr_out, o_dac_code};
            end else if (o_addr_ready) begin
                check("entry_stable", {o_addr_out, o_dac_code}, held);
            end
            if (o_dac_data_valid && !prev_dv) dv_cyc = cyc;
            if (o_dac_ack && !prev_ack) ack_cyc = cyc;
            if (prev_ack && i_ack_in) begin
                check("release_ready_low", o_addr_ready, 0);
                check("release_ack_low", o_dac_ack, 0);
            end
            prev_ready = o_addr_ready;
            prev_dv    = o_dac_data_valid;
            prev_ack   = o_dac_ack;
        end
    end

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_wr_ready"}, o_wr_ready, 1);
        check({pfx, "_addr_err"}, o_addr_err, 0);
        check({pfx, "_dac_code"}, o_dac_code, 0);
        check({pfx, "_dac_load"}, o_dac_load, 0);
        check({pfx, "_data_valid"}, o_dac_data_valid, 0);
        check({pfx, "_dac_ack"}, o_dac_ack, 0);
        check({pfx, "_addr_out"}, o_addr_out, 0);
        check({pfx, "_addr_ready"}, o_addr_ready, 0);
        check({pfx, "_busy"}, o_busy, 0);
        check({pfx, "_count"}, o_fifo_count, 0);
        check({pfx, "_timeout"}, o_timeout_err, 0);
    endtask

    initial begin
        bit acc;
        int base, tries;
        i_rst_n      = 1'b0;
        i_wr_valid   = 1'b0;
        i_wr_addr    = '0;
        i_wr_data    = '0;
        i_dac_enable = 1'b1;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("rst");
        #1 i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // single write
        base = loads;
        write_req(5'd5, 8'hA3, acc);
        check("t1_accept", acc, 1);
        wait_idle("t1_idle", 100);
        check("t1_loads", loads - base, 1);
        check("t1_load_lat", load_cyc - last_wr_cyc, 2);
        check("t1_settle_lat", dv_cyc - load_cyc, 4);
        check("t1_ack_lat", ack_cyc - load_cyc, 6);
        check("t1_busy", o_busy, 0);

        // out-of-range address, then the last legal one
        base = loads;
        write_req(5'd24, 8'h55, acc);
        check("err_pulse", o_addr_err, 1);
        check("err_count", o_fifo_count, 0);
        @(posedge i_clk); #1;
        check("err_pulse_end", o_addr_err, 0);
        repeat (10) @(negedge i_clk);
        check("err_no_load", loads - base, 0);
        check("err_busy", o_busy, 0);
        write_req(5'd23, 8'h7E, acc);
        check("edge_accept", acc, 1);
        check("edge_no_err", o_addr_err, 0);
        wait_idle("edge_idle", 100);

        // enable held low for 5 cycles of HOLD
        write_req(5'd9, 8'h3C, acc);
        for (int i = 0; i < 50; i++) begin
            @(negedge i_clk); #1;
            if (o_dac_data_valid) break;
        end
        i_dac_enable = 1'b0;
        repeat (5) @(negedge i_clk);
        #1 i_dac_enable = 1'b1;
        wait_idle("en_idle", 100);
        check("en_settle_lat", dv_cyc - load_cyc, 4);
        check("en_ack_lat", ack_cyc - load_cyc, 11);

        // burst of six with the router stalled
        router_stall = 1'b1;
        base = loads;
        for (int i = 0; i < 5; i++) begin
            write_req(ADDR_W'(i), DATA_W'(8'h10 + i), acc);
            check("burst_accept", acc, 1);
        end
        check("burst_count", o_fifo_count, 4);
        check("burst_full", o_wr_ready, 0);
        write_req(5'd5, 8'h15, acc);
        check("burst_reject", acc, 0);
        router_stall = 1'b0;
        tries = 0;
        do begin
            write_req(5'd5, 8'h15, acc);
            tries++;
        end while (!acc && tries < 100);
        check("burst_retry", acc, 1);
        wait_idle("burst_idle", 500);
        check("burst_loads", loads - base, 6);

        // reset while the first entry settles and three wait in the queue
        for (int i = 0; i < 4; i++) begin
            write_req(ADDR_W'(16 + i), DATA_W'(8'hC0 + i), acc);
        end
        check("mid_count", o_fifo_count, 3);
        check("mid_in_settle", o_addr_ready && !o_dac_load && !o_dac_data_valid, 1);
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        base = loads;
        repeat (2) @(negedge i_clk);
        #1 i_rst_n = 1'b1;
        repeat (20) @(negedge i_clk);
        check("mid_no_issue", loads - base, 0);
        check("mid_busy", o_busy, 0);
        check("mid_count_after", o_fifo_count, 0);
        check("final_timeout", o_timeout_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
